// File: rtl/mat_result_writer.sv
// Collects NUM_RES MAC results per run, saturates each to OUT_W bits and
// writes it to the output memory one cycle after the controller's strobe.
module mat_result_writer #(
  parameter int IN_W    = 19,
  parameter int OUT_W   = 16,
  parameter int NUM_RES = 16,
  parameter int ADDR_W  = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     start,
  input  logic                     wireOut,
  input  logic signed [IN_W-1:0]   mac_in,
  output logic                     wr_en,
  output logic [ADDR_W-1:0]        wr_addr,
  output logic signed [OUT_W-1:0]  wr_data,
  output logic [ADDR_W:0]          res_count,
  output logic                     busy,
  output logic                     done,
  output logic                     sat_flag,
  output logic                     overflow
);

  // state   | meaning
  // S_IDLE  | waiting for start; strobes ignored
  // S_COLLECT | accepting strobes until NUM_RES results are written
  // S_DONE  | run complete; held while start stays high
  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_DONE    = 2'd2
  } state_t;

  localparam logic signed [IN_W-1:0] SAT_MAX  = IN_W'((2 ** (OUT_W - 1)) - 1);
  localparam logic signed [IN_W-1:0] SAT_MIN  = IN_W'(-(2 ** (OUT_W - 1)));
  localparam logic [ADDR_W:0]        RES_LAST = (ADDR_W + 1)'(NUM_RES);

  state_t                   r_state;
  logic                     r_wr_en;
  logic [ADDR_W-1:0]        r_wr_addr;
  logic signed [OUT_W-1:0]  r_wr_data;
  logic [ADDR_W:0]          r_res_count;
  logic                     r_busy;
  logic                     r_done;
  logic                     r_sat;
  logic                     r_ovf;

  logic                     w_clip_hi;
  logic                     w_clip_lo;
  logic                     w_full;
  logic signed [OUT_W-1:0]  w_sat_data;

  assign w_clip_hi = (mac_in > SAT_MAX);
  assign w_clip_lo = (mac_in < SAT_MIN);
  assign w_full    = (r_res_count == RES_LAST);

  always_comb begin
    w_sat_data = mac_in[OUT_W-1:0];
    if (w_clip_hi) begin
      w_sat_data = SAT_MAX[OUT_W-1:0];
    end else if (w_clip_lo) begin
      w_sat_data = SAT_MIN[OUT_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_wr_en     <= 1'b0;
      r_wr_addr   <= '0;
      r_wr_data   <= '0;
      r_res_count <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_sat       <= 1'b0;
      r_ovf       <= 1'b0;
    end else begin
      r_wr_en <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state     <= S_COLLECT;
            r_busy      <= 1'b1;
            r_res_count <= '0;
            r_sat       <= 1'b0;
            r_ovf       <= 1'b0;
          end
        end
        S_COLLECT: begin
          // Leave one cycle after the last write so done trails it by one.
          if (w_full) begin
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            if (wireOut) r_ovf <= 1'b1;
          end else if (wireOut) begin
            r_wr_en     <= 1'b1;
            r_wr_addr   <= r_res_count[ADDR_W-1:0];
            r_wr_data   <= w_sat_data;
            r_res_count <= r_res_count + 1'b1;
            if (w_clip_hi || w_clip_lo) r_sat <= 1'b1;
          end
        end
        S_DONE: begin
          if (wireOut) r_ovf <= 1'b1;
          if (!start) begin
            r_state <= S_IDLE;
            r_done  <= 1'b0;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign wr_en     = r_wr_en;
  assign wr_addr   = r_wr_addr;
  assign wr_data   = r_wr_data;
  assign res_count = r_res_count;
  assign busy      = r_busy;
  assign done      = r_done;
  assign sat_flag  = r_sat;
  assign overflow  = r_ovf;

endmodule

// File: tb/tb_mat_result_writer.sv
// Directed and randomized bench for mat_result_writer against a run-level
// reference model of the result writer's behaviour.
module tb_mat_result_writer;

  localparam int NUM = 16;

  logic               clk;
  logic               reset_n;
  logic               start;
  logic               wireOut;
  logic signed [18:0] mac_in;
  logic               wr_en;
  logic [3:0]         wr_addr;
  logic signed [15:0] wr_data;
  logic [4:0]         res_count;
  logic               busy;
  logic               done;
  logic               sat_flag;
  logic               overflow;

  int total;
  int passed;

  // Reference model: phase 0 idle, 1 collecting, 2 finished.
  int m_phase;
  int m_cnt;
  int m_sat;
  int m_ovf;
  int m_wen;
  int m_addr;
  int m_data;
  logic signed [15:0] obs_mem [NUM];

  mat_result_writer dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .wireOut   (wireOut),
    .mac_in    (mac_in),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .res_count (res_count),
    .busy      (busy),
    .done      (done),
    .sat_flag  (sat_flag),
    .overflow  (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int clip16(input int v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic model_reset();
    m_phase = 0; m_cnt = 0; m_sat = 0; m_ovf = 0;
    m_wen = 0; m_addr = 0; m_data = 0;
  endtask

  task automatic model_edge(input bit s, input bit w, input int m);
    m_wen = 0;
    if (m_phase == 0) begin
      if (s) begin
        m_phase = 1; m_cnt = 0; m_sat = 0; m_ovf = 0;
      end
    end else if (m_phase == 1) begin
      if (m_cnt == NUM) begin
        m_phase = 2;
        if (w) m_ovf = 1;
      end else if (w) begin
        m_wen  = 1;
        m_addr = m_cnt;
        m_data = clip16(m);
        if (m_data != m) m_sat = 1;
        m_cnt++;
      end
    end else begin
      if (w) m_ovf = 1;
      if (!s) m_phase = 0;
    end
  endtask

  task automatic check_all();
    chk("wr_en",     wr_en,     m_wen);
    chk("wr_addr",   wr_addr,   m_addr);
    chk("wr_data",   wr_data,   m_data);
    chk("res_count", res_count, m_cnt);
    chk("busy",      busy,      (m_phase == 1) ? 1 : 0);
    chk("done",      done,      (m_phase == 2) ? 1 : 0);
    chk("sat_flag",  sat_flag,  m_sat);
    chk("overflow",  overflow,  m_ovf);
  endtask

  task automatic cyc(input bit s, input bit w, input int m);
    start   = s;
    wireOut = w;
    mac_in  = m[18:0];
    @(posedge clk);
    #1;
    model_edge(s, w, m);
    check_all();
    if (wr_en === 1'b1) obs_mem[wr_addr] = wr_data;
  endtask

  task automatic clear_mem();
    for (int i = 0; i < NUM; i++) obs_mem[i] = 'x;
  endtask

  function automatic int rand_mac();
    int r;
    r = int'($urandom_range(0, 9));
    case (r)
      0: return 32767;
      1: return 32768;
      2: return -32768;
      3: return -32769;
      default: return int'($urandom_range(0, 524287)) - 262144;
    endcase
  endfunction

  initial begin
    total = 0; passed = 0;
    reset_n = 1'b0; start = 1'b0; wireOut = 1'b0; mac_in = '0;
    model_reset();
    clear_mem();
    #3;
    check_all();
    start = 1'b1; wireOut = 1'b1;
    #20;
    check_all();
    start = 1'b0;
    reset_n = 1'b1;

    // Idle strobes are ignored.
    cyc(0, 1, 77);
    cyc(0, 1, -5);

    // Nominal run; strobe on the arming edge is dropped.
    cyc(1, 1, 999);
    for (int k = 0; k < NUM; k++) begin
      cyc(1, 1, k * 100);
      for (int g = 0; g < 7; g++) cyc(1, 0, 0);
    end
    for (int k = 0; k < NUM; k++) chk("nom_mem", obs_mem[k], k * 100);
    chk("nom_done", done, 1);
    chk("nom_sat", sat_flag, 0);

    // Strobe in DONE: overflow, no write; then leave and re-arm.
    cyc(1, 1, 1234);
    chk("ovf_nowrite", wr_en, 0);
    chk("ovf_set", overflow, 1);
    cyc(1, 0, 0);
    cyc(0, 0, 0);
    chk("idle_after_drop", done, 0);
    cyc(1, 0, 0);
    chk("rearm_ovf_clr", overflow, 0);
    chk("rearm_cnt_clr", res_count, 0);

    // Saturation, sticky flag, then back-to-back to finish the run.
    cyc(1, 1, 40000);
    chk("sat_hi", wr_data, 32767);
    cyc(0, 1, -40000);
    chk("sat_lo", wr_data, -32768);
    cyc(0, 1, 1000);
    chk("sat_sticky", sat_flag, 1);
    for (int k = 3; k < NUM; k++) cyc(0, 1, k);
    cyc(0, 1, 5);
    chk("b2b_done", done, 1);
    cyc(0, 0, 0);

    // Pure back-to-back run of NUM strobes.
    clear_mem();
    cyc(1, 0, 0);
    for (int k = 0; k < NUM; k++) cyc(1, 1, -k * 7);
    for (int k = 0; k < NUM; k++) chk("b2b_mem", obs_mem[k], -k * 7);
    cyc(1, 0, 0);
    chk("b2b_done2", done, 1);
    cyc(0, 0, 0);

    // Async reset mid-run after 5 writes, pending strobe discarded.
    cyc(1, 0, 0);
    for (int k = 0; k < 5; k++) begin
      cyc(0, 1, 300 + k);
      cyc(0, 0, 0);
    end
    start = 1'b1; wireOut = 1'b1; mac_in = 19'sd42;
    #3;
    reset_n = 1'b0;
    #1;
    model_reset();
    check_all();
    #2;
    reset_n = 1'b1;
    cyc(1, 1, 11);
    chk("rst_rearm_busy", busy, 1);
    cyc(1, 1, 22);
    chk("rst_addr0", wr_addr, 0);
    chk("rst_data", wr_data, 22);
    for (int k = 1; k < NUM; k++) cyc(0, 1, k);
    cyc(0, 0, 0);
    cyc(0, 0, 0);

    // Randomized runs with gaps, start toggling mid-run, and late strobes.
    for (int r = 0; r < 4; r++) begin
      cyc(1, 0, 0);
      for (int k = 0; k < NUM; k++) begin
        cyc(1'($urandom_range(0, 1)), 1, rand_mac());
        for (int g = int'($urandom_range(0, 3)); g > 0; g--)
          cyc(1'($urandom_range(0, 1)), 0, rand_mac());
      end
      for (int g = 0; g < 4; g++) cyc(1, 1'($urandom_range(0, 1)), rand_mac());
      cyc(0, 0, 0);
      cyc(0, 0, 0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
